// File: rtl/aes_mix_stage_pkg.sv
// aes_mix_stage_pkg: shared AES round constants, types and GF(2^8) helpers
package aes_mix_stage_pkg;
  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;
  typedef logic [127:0] state_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_st_e;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_mix_stage_gf_mix_column.sv
// gf_mix_column: one-column MixColumns, or InvMixColumns when dec_i is set
module gf_mix_column
  import aes_mix_stage_pkg::*;
(
  input  logic [31:0] col_i,
  input  logic        dec_i,
  output logic [31:0] col_o
);
  logic [7:0] a [4];
  logic [7:0] b [4];
  logic [7:0] u, v;
  // InvMixColumns = MixColumns after folding 4*(a0^a2) / 4*(a1^a3) into the column
  always_comb begin
    for (int i = 0; i < 4; i++) a[i] = col_i[31-8*i -: 8];
    u = dec_i ? xtime(xtime(a[0] ^ a[2])) : 8'h00;
    v = dec_i ? xtime(xtime(a[1] ^ a[3])) : 8'h00;
    b[0] = a[0] ^ u;
    b[1] = a[1] ^ v;
    b[2] = a[2] ^ u;
    b[3] = a[3] ^ v;
    col_o = '0;
    for (int i = 0; i < 4; i++)
      col_o[31-8*i -: 8] = xtime(b[i] ^ b[(i+1)%4]) ^ b[(i+1)%4] ^ b[(i+2)%4] ^ b[(i+3)%4];
  end
endmodule

// File: rtl/aes_mix_stage.sv
// aes_mix_stage: AES (Inv)MixColumns round stage with a 2-entry valid/ready elastic buffer
module aes_mix_stage
  import aes_mix_stage_pkg::*;
#(
  parameter int NR     = NR_AES128,
  parameter int NUM_W  = 4,
  parameter bit EN_DEC = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  state_t           in_state_i,
  input  state_t           in_key_i,
  input  logic [NUM_W-1:0] in_num_i,
  input  logic             in_dec_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output state_t           out_state_o,
  output state_t           out_key_o,
  output logic [NUM_W-1:0] out_num_o,
  output logic             out_dec_o,
  output logic             out_err_o
);
  localparam int EW = 256 + NUM_W + 2;
  localparam logic [NUM_W-1:0] NR_L = NUM_W'(NR);
  buf_st_e st_q, st_d;
  logic [EW-1:0] head_q, head_d, skid_q, skid_d, new_e;
  logic rdy_q, dec, err, byp, in_xfer, out_xfer;
  state_t mixed;
  assign dec = EN_DEC && in_dec_i;
  assign err = (in_num_i == '0) || (in_num_i > NR_L);
  assign byp = err || (in_num_i == NR_L);
  for (genvar c = 0; c < 4; c++) begin : g_col
    gf_mix_column u_col (
      .col_i(in_state_i[127-32*c -: 32]),
      .dec_i(dec),
      .col_o(mixed[127-32*c -: 32])
    );
  end
  assign new_e = {byp ? in_state_i : mixed, in_key_i, in_num_i, dec, err};
  assign {out_state_o, out_key_o, out_num_o, out_dec_o, out_err_o} = head_q;
  assign out_valid_o = (st_q != EMPTY);
  assign in_ready_o = rdy_q;
  assign in_xfer = in_valid_i && rdy_q;
  assign out_xfer = out_valid_o && out_ready_i;
  always_comb begin
    st_d = st_q;
    head_d = head_q;
    skid_d = skid_q;
    case (st_q)
      EMPTY: if (in_xfer) begin
        head_d = new_e;
        st_d = ONE;
      end
      ONE: if (in_xfer && out_xfer) head_d = new_e;
        else if (in_xfer) begin
          skid_d = new_e;
          st_d = FULL;
        end else if (out_xfer) st_d = EMPTY;
      FULL: if (out_xfer) begin
        head_d = skid_q;
        st_d = ONE;
      end
      default: st_d = EMPTY;
    endcase
  end
  // in_ready is registered from the next state so it never sees out_ready combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= EMPTY;
      head_q <= '0;
      skid_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      st_q <= st_d;
      head_q <= head_d;
      skid_q <= skid_d;
      rdy_q <= (st_d != FULL);
    end
  end
endmodule

// File: tb/tb_aes_mix_stage.sv
// tb_aes_mix_stage: directed vector table plus stream/backpressure/reset sequences
module tb_aes_mix_stage;
  typedef struct {
    logic [127:0] st;
    logic [3:0]   num;
    logic         dec;
    logic [127:0] exp;
    logic         err;
  } vec_t;
  localparam int NV = 9;
  localparam logic [127:0] A  = 128'hdb135345_f20a225c_c6c6c6c6_01010101;
  localparam logic [127:0] AM = 128'h8e4da1bc_9fdc589d_c6c6c6c6_01010101;
  localparam logic [127:0] B  = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
  localparam logic [127:0] BM = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, in_dec = 0, out_valid, out_ready = 0, out_dec, out_err;
  logic [127:0] in_state = '0, in_key = '0, out_state, out_key;
  logic [3:0] in_num = '0, out_num;
  vec_t vecs [NV];
  int n_tests = 0, n_fail = 0;
  int acc, rdy_s, first, span, drops;
  aes_mix_stage #(.NR(10), .NUM_W(4), .EN_DEC(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_state_i(in_state), .in_key_i(in_key),
    .in_num_i(in_num), .in_dec_i(in_dec),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_state_o(out_state), .out_key_o(out_key),
    .out_num_o(out_num), .out_dec_o(out_dec), .out_err_o(out_err)
  );
  always #5 clk = ~clk;
  function automatic logic [127:0] key_of(input int i);
    return {16{8'(i * 7 + 3)}};
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input int i);
    in_valid = 1;
    in_state = vecs[i % NV].st;
    in_key = key_of(i);
    in_num = vecs[i % NV].num;
    in_dec = vecs[i % NV].dec;
  endtask
  task automatic chk_out(input int i);
    chk($sformatf("state[%0d]", i), out_state, vecs[i % NV].exp);
    chk($sformatf("key[%0d]", i), out_key, key_of(i));
    chk($sformatf("num[%0d]", i), 128'(out_num), 128'(vecs[i % NV].num));
    chk($sformatf("dec[%0d]", i), 128'(out_dec), 128'(vecs[i % NV].dec));
    chk($sformatf("err[%0d]", i), 128'(out_err), 128'(vecs[i % NV].err));
  endtask
  task automatic stream(input int base, input int n, input int stall, output int acc_o,
                        output int rdy_o, output int first_o, output int span_o, output int drops_o);
    int idx = 0, rx = 0, cyc = 0, last = 0;
    bit take;
    first_o = -1; acc_o = 0; rdy_o = 0; drops_o = 0;
    out_ready = (stall == 0);
    drive(base);
    while (rx < n && cyc < 200) begin
      if (cyc == stall && stall > 0) begin
        acc_o = idx;
        rdy_o = int'(in_ready);
        out_ready = 1;
      end
      if (out_valid && out_ready) begin
        chk_out(base + rx);
        if (first_o < 0) first_o = cyc;
        last = cyc;
        rx++;
      end
      if (idx < n && !in_ready) drops_o++;
      take = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (take) idx++;
      if (idx < n) drive(base + idx);
      else in_valid = 0;
    end
    chk("stream_done", 128'(rx), 128'(n));
    span_o = last - first_o + 1;
  endtask
  initial begin
    vecs[0] = '{A, 4'd1, 1'b0, AM, 1'b0};
    vecs[1] = '{AM, 4'd1, 1'b1, A, 1'b0};
    vecs[2] = '{B, 4'd5, 1'b0, BM, 1'b0};
    vecs[3] = '{BM, 4'd9, 1'b1, B, 1'b0};
    vecs[4] = '{A, 4'd10, 1'b0, A, 1'b0};
    vecs[5] = '{AM, 4'd10, 1'b1, AM, 1'b0};
    vecs[6] = '{A, 4'd0, 1'b0, A, 1'b1};
    vecs[7] = '{B, 4'd15, 1'b1, B, 1'b1};
    vecs[8] = '{BM, 4'd11, 1'b0, BM, 1'b1};
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_state", out_state, '0);
    rst_n = 1;
    chk("rel_in_ready_before_clk", 128'(in_ready), 128'(0));
    @(negedge clk);
    chk("rel_in_ready_after_clk", 128'(in_ready), 128'(1));
    for (int i = 0; i < NV; i++) begin
      stream(i, 1, 0, acc, rdy_s, first, span, drops);
      chk($sformatf("latency[%0d]", i), 128'(first), 128'(1));
    end
    stream(0, 8, 6, acc, rdy_s, first, span, drops);
    chk("bp_accepted", 128'(acc), 128'(2));
    chk("bp_in_ready", 128'(rdy_s), 128'(0));
    stream(0, 16, 0, acc, rdy_s, first, span, drops);
    chk("tp_first", 128'(first), 128'(1));
    chk("tp_span", 128'(span), 128'(16));
    chk("tp_ready_drops", 128'(drops), 128'(0));
    out_ready = 0;
    drive(2);
    @(negedge clk);
    drive(3);
    @(negedge clk);
    in_valid = 0;
    chk("full_in_ready", 128'(in_ready), 128'(0));
    chk("full_out_valid", 128'(out_valid), 128'(1));
    #2 rst_n = 0;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'(0));
    chk("arst_state", out_state, '0);
    chk("arst_key", out_key, '0);
    chk("arst_misc", 128'({out_num, out_dec, out_err, in_ready}), 128'(0));
    @(negedge clk);
    rst_n = 1;
    chk("arel_in_ready0", 128'(in_ready), 128'(0));
    @(negedge clk);
    chk("arel_in_ready1", 128'(in_ready), 128'(1));
    chk("arel_out_valid", 128'(out_valid), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
